// File: rtl/common.sv
// Shared scheduler types and RV32I base opcodes, plus the decode of which
// register fields an opcode actually uses.
package common;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } reg_use_t;

    // Unlisted opcodes are treated like an I-type: read rs1, write rd.
    function automatic reg_use_t decode_use(input logic [6:0] opc);
        reg_use_t u;
        u.rs1 = 1'b1;
        u.rs2 = 1'b0;
        u.rd  = 1'b1;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: u.rs1 = 1'b0;
            OPC_BRANCH: begin
                u.rs2 = 1'b1;
                u.rd  = 1'b0;
            end
            OPC_STORE: begin
                u.rs2 = 1'b1;
                u.rd  = 1'b0;
            end
            OPC_OP: u.rs2 = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: u.rs2 = 1'b0;
            default: u.rs2 = 1'b0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy vector and in-flight write counter with a sticky error flag
// for write-backs that have no matching outstanding write.
module reg_scoreboard #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        clr_en,
    input  logic [4:0]  clr_rd,
    output logic [31:0] busy,
    output logic        full,
    output logic        error
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic [31:0]   busy_q, busy_d;
    logic [CW-1:0] count_q, count_d;
    logic          error_q, error_d;

    // Set is applied after clear so a same-register collision leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;

        count_d = count_q;
        if (set_en && !clr_en) begin
            count_d = count_q + CW'(1);
        end else if (!set_en && clr_en && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end

        error_d = error_q;
        if (clr_en && ((count_q == '0) || ((clr_rd != 5'd0) && !busy_q[clr_rd]))) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign busy  = busy_q;
    assign full  = (count_q == MAX_CNT);
    assign error = error_q;

endmodule

// File: rtl/decode_scheduler.sv
// Decode-stage issue control: register hazards, in-flight capacity limit and
// the post-redirect squash window.
module decode_scheduler #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       ex_ready,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       redirect,
    output logic       issue,
    output logic       stall_if,
    output logic       flush_id,
    output logic       sb_error
);

    import common::*;

    localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

    sched_state_t  state_q, state_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    reg_use_t    use_c;
    logic [31:0] busy;
    logic        sb_full;
    logic        writes_rd;
    logic        hazard;
    logic        issue_c;
    logic        flush_c;
    logic        sb_set;

    reg_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_sb (
        .clk    (clk),
        .reset  (reset),
        .set_en (sb_set),
        .set_rd (id_rd),
        .clr_en (wb_valid),
        .clr_rd (wb_rd),
        .busy   (busy),
        .full   (sb_full),
        .error  (sb_error)
    );

    // Hazards look only at the registered busy vector; write-back is not bypassed.
    always_comb begin
        use_c     = decode_use(id_opcode);
        writes_rd = use_c.rd && (id_rd != 5'd0);
        hazard    = (use_c.rs1 && busy[id_rs1]) ||
                    (use_c.rs2 && busy[id_rs2]) ||
                    (use_c.rd  && busy[id_rd]);
        flush_c   = redirect || (state_q == FLUSH);
        issue_c   = id_valid && ex_ready && (state_q == RUN) && !redirect &&
                    !hazard && !(sb_full && writes_rd);
        sb_set    = issue_c && writes_rd;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (redirect && (FLUSH_CYCLES > 0)) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q <= FW'(1)) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign issue    = issue_c;
    assign flush_id = flush_c;
    assign stall_if = id_valid && !issue_c && !flush_c;

endmodule

// File: tb/tb_decode_scheduler.sv
// Directed scoreboard bench: the driver queues hand-computed expectations per
// cycle and a negedge monitor pops and compares them.
module tb_decode_scheduler;

    import common::*;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       redirect;
    logic       issue, stall_if, flush_id, sb_error;

    typedef struct {
        string        name;
        logic         issue;
        logic         stall;
        logic         flush;
        logic         err;
        logic [31:0]  busy;
        logic [2:0]   cnt;
        sched_state_t st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;

    decode_scheduler #(
        .MAX_INFLIGHT (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .ex_ready  (ex_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .redirect  (redirect),
        .issue     (issue),
        .stall_if  (stall_if),
        .flush_id  (flush_id),
        .sb_error  (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s %s actual=%0h expected=%0h", tag, fld, act, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp(e.name, "issue",    32'(issue),    32'(e.issue));
        cmp(e.name, "stall_if", 32'(stall_if), 32'(e.stall));
        cmp(e.name, "flush_id", 32'(flush_id), 32'(e.flush));
        cmp(e.name, "sb_error", 32'(sb_error), 32'(e.err));
        cmp(e.name, "busy",     dut.u_sb.busy_q,        e.busy);
        cmp(e.name, "count",    32'(dut.u_sb.count_q), 32'(e.cnt));
        cmp(e.name, "state",    32'(dut.state_q),       32'(e.st));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic pushExp(input string name, input logic ei, es, ef, ee,
                           input logic [31:0] eb, input logic [2:0] ec,
                           input sched_state_t est);
        exp_t e;
        e.name = name; e.issue = ei; e.stall = es; e.flush = ef; e.err = ee;
        e.busy = eb; e.cnt = ec; e.st = est;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input string name, input logic v, input logic [6:0] opc,
                                 input logic [4:0] rs1, rs2, rd, input logic er,
                                 input logic wbv, input logic [4:0] wbr, input logic redir,
                                 input logic ei, es, ef, ee,
                                 input logic [31:0] eb, input logic [2:0] ec,
                                 input sched_state_t est);
        @(posedge clk);
        #1;
        id_valid = v; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        ex_ready = er; wb_valid = wbv; wb_rd = wbr; redirect = redir;
        pushExp(name, ei, es, ef, ee, eb, ec, est);
    endtask

    task automatic idleInputs();
        id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; redirect = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        pushExp("reset", 0, 0, 0, 0, 32'h0, 3'd0, RUN);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // RAW stall, plus ex_ready low blocking issue
        applyStimulus("raw_exnr",     1, OP,  1, 2, 5, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,  3'd0, RUN);
        applyStimulus("raw_add",      1, OP,  1, 2, 5, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0,  3'd0, RUN);
        applyStimulus("raw_stall",    1, OPI, 5, 0, 6, 1, 0, 0, 0, 0, 1, 0, 0, 32'h20, 3'd1, RUN);
        applyStimulus("raw_stall_wb", 1, OPI, 5, 0, 6, 1, 1, 5, 0, 0, 1, 0, 0, 32'h20, 3'd1, RUN);
        applyStimulus("raw_issue",    1, OPI, 5, 0, 6, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0,  3'd0, RUN);
        applyStimulus("raw_wb6",      0, OP,  0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 32'h40, 3'd1, RUN);

        // Capacity limit
        applyStimulus("cap_ld1",      1, LD, 10, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0,  3'd0, RUN);
        applyStimulus("cap_ld2",      1, LD, 10, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 32'h2,  3'd1, RUN);
        applyStimulus("cap_ld3",      1, LD, 10, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 32'h6,  3'd2, RUN);
        applyStimulus("cap_ld4",      1, LD, 10, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 32'hE,  3'd3, RUN);
        applyStimulus("cap_full",     1, LD, 10, 0, 7, 1, 0, 0, 0, 0, 1, 0, 0, 32'h1E, 3'd4, RUN);
        applyStimulus("cap_full_wb",  1, LD, 10, 0, 7, 1, 1, 1, 0, 0, 1, 0, 0, 32'h1E, 3'd4, RUN);
        applyStimulus("cap_release",  1, LD, 10, 0, 7, 1, 0, 0, 0, 1, 0, 0, 0, 32'h1C, 3'd3, RUN);
        applyStimulus("cap_wb2",      0, OP,  0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 32'h9C, 3'd4, RUN);
        applyStimulus("cap_wb3",      0, OP,  0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 32'h98, 3'd3, RUN);
        applyStimulus("cap_wb4",      0, OP,  0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 32'h90, 3'd2, RUN);
        applyStimulus("cap_wb7",      0, OP,  0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 32'h80, 3'd1, RUN);

        // Redirect squash window
        applyStimulus("rd_add8",      1, OP,  1, 2, 8, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0,   3'd0, RUN);
        applyStimulus("rd_pulse",     1, OP,  1, 2, 10, 1, 0, 0, 1, 0, 0, 1, 0, 32'h100, 3'd1, RUN);
        applyStimulus("rd_flush1",    1, OP,  1, 2, 10, 1, 0, 0, 0, 0, 0, 1, 0, 32'h100, 3'd1, FLUSH);
        applyStimulus("rd_flush2",    1, OP,  1, 2, 10, 1, 0, 0, 0, 0, 0, 1, 0, 32'h100, 3'd1, FLUSH);
        applyStimulus("rd_done",      0, OP,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 3'd1, RUN);

        // Set/clear collision on x9 (x9 was not busy, so the write-back is flagged)
        applyStimulus("col_issue9",   1, OP,  1, 2, 9, 1, 1, 9, 0, 1, 0, 0, 0, 32'h100, 3'd1, RUN);
        applyStimulus("col_after",    0, OP,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 3'd1, RUN);

        doReset();

        // x0 destination and store do not occupy the scoreboard
        applyStimulus("x0_addi",      1, OPI, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0, RUN);
        applyStimulus("sw",           1, ST,  1, 2, 5, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0, RUN);
        applyStimulus("spur_wb",      0, OP,  0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 32'h0, 3'd0, RUN);
        applyStimulus("err_set",      0, OP,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 3'd0, RUN);

        doReset();

        // Redirect reload inside FLUSH, then async reset mid-flush
        applyStimulus("f_add5",       1, OP, 1, 2, 5, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0,  3'd0, RUN);
        applyStimulus("f_redir1",     1, OP, 1, 2, 6, 1, 0, 0, 1, 0, 0, 1, 0, 32'h20, 3'd1, RUN);
        applyStimulus("f_flush_a",    1, OP, 1, 2, 6, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 3'd1, FLUSH);
        applyStimulus("f_redir2",     1, OP, 1, 2, 6, 1, 0, 0, 1, 0, 0, 1, 0, 32'h20, 3'd1, FLUSH);
        applyStimulus("f_reload",     1, OP, 1, 2, 6, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 3'd1, FLUSH);
        @(posedge clk);
        #2;
        idleInputs();
        reset = 1'b1;
        pushExp("async_rst", 0, 0, 0, 0, 32'h0, 3'd0, RUN);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus("post_rst",     1, OP, 1, 2, 6, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0, RUN);
        @(posedge clk);
        #1;
        idleInputs();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_scheduler.md
DECODE_SCHEDULER -- requirements
Module: decode_scheduler

Interface
REQ-001 Parameter MAX_INFLIGHT, default 4: maximum issued register-writing instructions not yet written back.
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles the decode slot is squashed after a redirect.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 id_valid  in  1  decode slot holds an instruction.
REQ-006 id_opcode  in  7  opcode of the decoded instruction.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  decoded register indices.
REQ-008 ex_ready  in  1  execute stage accepts an instruction this cycle.
REQ-009 wb_valid  in  1  write-back retires a register write this cycle.
REQ-010 wb_rd  in  5  register written back.
REQ-011 redirect  in  1  execute resolved a taken branch, JAL or JALR.
REQ-012 issue  out  1  decode instruction moves to execute this cycle.
REQ-013 stall_if  out  1  fetch and IF/ID register hold.
REQ-014 flush_id  out  1  IF/ID register loads a bubble.
REQ-015 sb_error  out  1  sticky protocol-error flag.

Function
REQ-016 Usage from id_opcode: rs1 used by all except LUI, AUIPC, JAL; rs2 used by ARITHMETIC, BRANCH, STORE; rd written by all except BRANCH, STORE; rd = 0 never counts as written.
REQ-017 Scoreboard: 32-bit busy vector; bit 0 permanently 0.
REQ-018 Issue sets busy[id_rd] when rd written and id_rd != 0; wb_valid clears busy[wb_rd].
REQ-019 If the same register is set and cleared in one cycle, set wins.
REQ-020 Hazard checks use the registered busy vector; no same-cycle write-back bypass, so a dependent instruction issues the cycle after wb_valid at the earliest.
REQ-021 Hazard = (rs1 used and busy[rs1]) or (rs2 used and busy[rs2]) or (rd written and busy[rd]) (WAW).
REQ-022 Inflight counter, width clog2(MAX_INFLIGHT+1): +1 on issue of a register-writing instruction with rd != 0; -1 on wb_valid; unchanged when both occur.
REQ-023 issue = id_valid and ex_ready and state RUN and not redirect and not hazard and not (counter = MAX_INFLIGHT and the instruction writes rd != 0).
REQ-024 stall_if = id_valid and not issue and not flush_id.
REQ-025 Issue is combinational, zero-latency; no output depends on the registered state except through state, busy and counter.
REQ-026 FSM states RUN and FLUSH.
REQ-027 RUN -> FLUSH on redirect; flush_id = 1 in the redirect cycle and every FLUSH cycle.
REQ-028 FLUSH lasts FLUSH_CYCLES cycles via a down-counter, then returns to RUN.
REQ-029 A redirect while in FLUSH reloads the down-counter.
REQ-030 Scoreboard and counter are not cleared by redirect, because older issued instructions still retire.
REQ-031 wb_valid with counter = 0 or busy[wb_rd] = 0 (wb_rd != 0) sets sb_error; counter does not underflow.

Reset
REQ-032 Asynchronous assertion forces state RUN, busy all 0, counter 0, flush down-counter 0 and sb_error 0.
REQ-033 With id_valid = 0 and redirect = 0 during reset, issue, stall_if and flush_id are 0.
REQ-034 Reset mid-flush abandons the flush; operation restarts in RUN at the first clock after deassertion.

Structure
REQ-035 Shared package common holds sched_state_t (RUN, FLUSH) and reuses the existing opcode constants.
REQ-036 The scoreboard, busy vector plus inflight counter, is one sub-module named reg_scoreboard; usage decode, FSM and issue logic stay in decode_scheduler.

Verification
REQ-037 Bench scenario, RAW stall: issue ADD x5 (counter 0 -> 1, busy[5] = 1), then ADDI x6, x5 -> stall_if = 1 until wb_valid with wb_rd = 5; issue occurs exactly one cycle later.
REQ-038 Bench scenario, capacity: 4 back-to-back loads to x1..x4 issue with no hazards, then a 5th load to x7 stalls (counter = 4); one wb_valid releases it the next cycle.
REQ-039 Bench scenario, redirect: redirect pulse with id_valid = 1 -> flush_id high 3 cycles (redirect cycle + 2), issue = 0 throughout, busy vector unchanged.
REQ-040 Bench scenario, set/clear collision: issue to x9 in the same cycle as wb_valid with wb_rd = 9 -> busy[9] = 1 and counter unchanged.
REQ-041 Bench scenario, x0 and STORE: ADDI x0 and SW issue freely, counter stays 0; a spurious wb_valid with wb_rd = 3 while idle sets sb_error.
REQ-042 Bench scenario, async reset: assert reset mid-FLUSH with busy nonzero -> all outputs 0 and state RUN without a clock edge.
